// File: rtl/ctrl_pkg.sv
// Shared constants for the pipeline control unit: opcodes, the control-word layout,
// the decoded control words and the PC-select encodings.
package ctrl_pkg;

    localparam int OP_R_FORMAT = 0;
    localparam int OP_J        = 2;
    localparam int OP_BEQ      = 4;
    localparam int OP_ADDIU    = 9;
    localparam int OP_LW       = 35;
    localparam int OP_SW       = 43;

    // Control word = {RegDst, ALUOp[1:0], ALUSrc, Branch, Jump, MemRead, MemWrite, RegWrite, MemtoReg, ExtSel}
    localparam int CTRL_W      = 11;
    localparam int CW_EXTSEL   = 0;
    localparam int CW_MEMTOREG = 1;
    localparam int CW_REGWRITE = 2;
    localparam int CW_MEMWRITE = 3;
    localparam int CW_MEMREAD  = 4;
    localparam int CW_JUMP     = 5;
    localparam int CW_BRANCH   = 6;
    localparam int CW_ALUSRC   = 7;
    localparam int CW_ALUOP_LO = 8;
    localparam int CW_ALUOP_HI = 9;
    localparam int CW_REGDST   = 10;

    localparam logic [CTRL_W-1:0] WORD_R     = 11'b1_10_0_0_0_0_0_1_0_0;
    localparam logic [CTRL_W-1:0] WORD_ADDIU = 11'b0_00_1_0_0_0_0_1_0_1;
    localparam logic [CTRL_W-1:0] WORD_LW    = 11'b0_00_1_0_0_1_0_1_1_1;
    localparam logic [CTRL_W-1:0] WORD_SW    = 11'b0_00_1_0_0_0_1_0_0_1;
    localparam logic [CTRL_W-1:0] WORD_BEQ   = 11'b0_01_0_1_0_0_0_0_0_1;
    localparam logic [CTRL_W-1:0] WORD_J     = 11'b0_00_0_0_1_0_0_0_0_0;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/control_decode.sv
// Pure combinational opcode decoder: produces the control word and flags unknown opcodes.
// Unknown (or unresolved) opcodes yield the all-zero word so nothing unknown propagates.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0]  opcode,
    output logic [CTRL_W-1:0] word,
    output logic              illegal
);

    // Opcode lookup; default catches unimplemented opcodes
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_W'(OP_R_FORMAT): word = WORD_R;
            OPC_W'(OP_ADDIU):    word = WORD_ADDIU;
            OPC_W'(OP_LW):       word = WORD_LW;
            OPC_W'(OP_SW):       word = WORD_SW;
            OPC_W'(OP_BEQ):      word = WORD_BEQ;
            OPC_W'(OP_J):        word = WORD_J;
            default:             illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_pipeline_unit.sv
// Pipelined control unit: decodes in ID, carries the control word through ID/EX, EX/MEM
// and MEM/WB, and resolves load-use stalls, taken branches and jumps.
// Redirect priority: taken branch > load-use stall > jump.
module control_pipeline_unit
    import ctrl_pkg::*;
#(
    parameter int OPC_W     = 6,
    parameter int REG_W     = 5,
    parameter int ALUOP_W   = 2,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OPC_W-1:0]   opcode_id,
    input  logic [REG_W-1:0]   rs_id,
    input  logic [REG_W-1:0]   rt_id,
    input  logic               zero_ex,
    output logic               ext_sel_id,
    output logic               ex_reg_dst,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic               ex_alu_src,
    output logic [REG_W-1:0]   ex_rt,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic [1:0]         pc_sel,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   stall_cnt
);

    logic [CTRL_W-1:0] dec_word;
    logic [CTRL_W-1:0] idex_word;
    logic [CTRL_W-1:0] exmem_word;
    logic [CTRL_W-1:0] memwb_word;
    logic              dec_illegal;
    logic              uses_rt;
    logic              load_use;
    logic              stall;
    logic              br_tk;
    logic              bubble;

    control_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode  (opcode_id),
        .word    (dec_word),
        .illegal (dec_illegal)
    );

    // Instructions that actually read rt as a source operand
    always_comb begin
        uses_rt = (opcode_id == OPC_W'(OP_R_FORMAT)) ||
                  (opcode_id == OPC_W'(OP_SW)) ||
                  (opcode_id == OPC_W'(OP_BEQ));
    end

    // Hazard detection; a taken branch squashes the dependent instruction, so it overrides the stall
    always_comb begin
        load_use = idex_word[CW_MEMREAD] && (ex_rt != '0) &&
                   ((ex_rt == rs_id) || ((ex_rt == rt_id) && uses_rt));
        br_tk    = idex_word[CW_BRANCH] && zero_ex;
        stall    = (HAZARD_EN != 0) && load_use && !br_tk;
        bubble   = br_tk || stall;
    end

    // PC / IF-ID steering
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        pc_sel     = PC_SEL_SEQ;
        if (br_tk) begin
            pc_sel     = PC_SEL_BRANCH;
            ifid_flush = 1'b1;
        end else if (stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (dec_word[CW_JUMP]) begin
            pc_sel     = PC_SEL_JUMP;
            ifid_flush = 1'b1;
        end
    end

    // Stage registers; a bubble replaces the ID/EX entry while later stages keep draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_word  <= '0;
            ex_rt      <= '0;
            exmem_word <= '0;
            memwb_word <= '0;
        end else begin
            idex_word  <= bubble ? '0 : dec_word;
            ex_rt      <= bubble ? '0 : rt_id;
            exmem_word <= idex_word;
            memwb_word <= exmem_word;
        end
    end

    // Illegal-opcode pulse; a stalled opcode is reported when it finally issues
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= dec_illegal && !bubble;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign ext_sel_id    = dec_word[CW_EXTSEL];
    assign ex_reg_dst    = idex_word[CW_REGDST];
    assign ex_alu_op     = ALUOP_W'(idex_word[CW_ALUOP_HI:CW_ALUOP_LO]);
    assign ex_alu_src    = idex_word[CW_ALUSRC];
    assign mem_read      = exmem_word[CW_MEMREAD];
    assign mem_write     = exmem_word[CW_MEMWRITE];
    assign wb_reg_write  = memwb_word[CW_REGWRITE];
    assign wb_mem_to_reg = memwb_word[CW_MEMTOREG];

endmodule

// File: tb/tb_control_pipeline_unit.sv
// Directed bench for control_pipeline_unit. The stall counter is narrowed to 2 bits so
// saturation is reachable in a short run. Inputs change 1 ns after each rising edge.
module tb_control_pipeline_unit;

    localparam int OPC_W = 6;
    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_J   = 6'd2;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_ADI = 6'd9;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_BAD = 6'd63;

    logic             clk;
    logic             rst;
    logic [OPC_W-1:0] opcode_id;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             zero_ex;
    logic             ext_sel_id;
    logic             ex_reg_dst;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src;
    logic [REG_W-1:0] ex_rt;
    logic             mem_read;
    logic             mem_write;
    logic             wb_reg_write;
    logic             wb_mem_to_reg;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic [1:0]       pc_sel;
    logic             illegal_op;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    control_pipeline_unit #(
        .OPC_W(OPC_W), .REG_W(REG_W), .ALUOP_W(2), .HAZARD_EN(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id),
        .zero_ex(zero_ex), .ext_sel_id(ext_sel_id), .ex_reg_dst(ex_reg_dst),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_rt(ex_rt),
        .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .pc_sel(pc_sel), .illegal_op(illegal_op),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        opcode_id = op;
        rs_id     = rs;
        rt_id     = rt;
        #1;
    endtask

    initial begin
        rst = 1'b0; opcode_id = '0; rs_id = '0; rt_id = '0; zero_ex = 1'b0;
        #2;
        check("rst_ex_reg_dst", ex_reg_dst, 0);
        check("rst_mem_read", mem_read, 0);
        check("rst_wb_reg_write", wb_reg_write, 0);
        check("rst_pc_write", pc_write, 1);
        check("rst_ifid_write", ifid_write, 1);
        check("rst_pc_sel", pc_sel, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b1;

        // R then ADDIU, no hazards
        set_id(OP_R, 5'd1, 5'd2);
        check("r_ext_sel", ext_sel_id, 0);
        check("r_ifid_flush", ifid_flush, 0);
        cyc();
        check("r_ex_reg_dst", ex_reg_dst, 1);
        check("r_ex_alu_op", ex_alu_op, 2);
        check("r_ex_alu_src", ex_alu_src, 0);
        check("r_ex_rt", ex_rt, 2);
        set_id(OP_ADI, 5'd3, 5'd4);
        check("addiu_ext_sel", ext_sel_id, 1);
        cyc();
        check("addiu_ex_reg_dst", ex_reg_dst, 0);
        check("addiu_ex_alu_src", ex_alu_src, 1);
        check("addiu_ex_alu_op", ex_alu_op, 0);
        check("r_wb_not_yet", wb_reg_write, 0);
        set_id(OP_R, 5'd0, 5'd0);
        cyc();
        check("r_wb_reg_write", wb_reg_write, 1);
        check("r_wb_mem_to_reg", wb_mem_to_reg, 0);
        cyc();
        check("addiu_wb_reg_write", wb_reg_write, 1);

        // LW $8 then ADD rs=$8: one stall cycle
        set_id(OP_LW, 5'd1, 5'd8);
        check("lw_no_stall", pc_write, 1);
        cyc();
        set_id(OP_R, 5'd8, 5'd9);
        check("lu_pc_write", pc_write, 0);
        check("lu_ifid_write", ifid_write, 0);
        check("lu_pc_sel", pc_sel, 0);
        cyc();
        check("lu_bubble_reg_dst", ex_reg_dst, 0);
        check("lu_bubble_alu_op", ex_alu_op, 0);
        check("lu_mem_read", mem_read, 1);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_released", pc_write, 1);
        cyc();
        check("lu_add_in_ex", ex_reg_dst, 1);
        check("lu_bubble_mem", mem_read, 0);
        check("lu_wb_mem_to_reg", wb_mem_to_reg, 1);
        check("lu_stall_cnt_hold", stall_cnt, 1);

        // LW $8 then SW rt=$8: stall
        set_id(OP_LW, 5'd1, 5'd8);
        cyc();
        set_id(OP_SW, 5'd2, 5'd8);
        check("sw_stall", pc_write, 0);
        cyc();
        check("sw_stall_cnt", stall_cnt, 2);
        check("sw_released", pc_write, 1);
        cyc();
        check("sw_ex_alu_src", ex_alu_src, 1);

        // LW $8 then ADDIU rt=$8: rt is a destination, no stall
        set_id(OP_LW, 5'd1, 5'd8);
        cyc();
        check("sw_mem_write", mem_write, 1);
        set_id(OP_ADI, 5'd3, 5'd8);
        check("addiu_rt_no_stall", pc_write, 1);
        cyc();
        check("addiu_rt_cnt", stall_cnt, 2);

        // LW $0 then use $0: no stall
        set_id(OP_LW, 5'd1, 5'd0);
        cyc();
        set_id(OP_R, 5'd0, 5'd0);
        check("r0_no_stall", pc_write, 1);
        cyc();
        check("r0_cnt", stall_cnt, 2);

        // Jump in ID
        set_id(OP_J, 5'd0, 5'd0);
        check("j_pc_sel", pc_sel, 2);
        check("j_ifid_flush", ifid_flush, 1);
        check("j_pc_write", pc_write, 1);
        cyc();
        check("j_ex_alu_op", ex_alu_op, 0);
        check("j_ex_reg_dst", ex_reg_dst, 0);

        // BEQ taken with a would-be dependent R in ID
        set_id(OP_BEQ, 5'd1, 5'd2);
        cyc();
        check("beq_ex_alu_op", ex_alu_op, 1);
        zero_ex = 1'b1;
        set_id(OP_R, 5'd8, 5'd8);
        check("br_pc_sel", pc_sel, 1);
        check("br_ifid_flush", ifid_flush, 1);
        check("br_pc_write", pc_write, 1);
        cyc();
        zero_ex = 1'b0;
        check("br_flushed_reg_dst", ex_reg_dst, 0);
        check("br_cnt", stall_cnt, 2);

        // BEQ not taken
        set_id(OP_BEQ, 5'd1, 5'd2);
        cyc();
        set_id(OP_R, 5'd0, 5'd0);
        check("bnt_pc_sel", pc_sel, 0);
        check("bnt_ifid_flush", ifid_flush, 0);
        cyc();

        // Taken branch beats jump in ID
        set_id(OP_BEQ, 5'd1, 5'd2);
        cyc();
        zero_ex = 1'b1;
        set_id(OP_J, 5'd0, 5'd0);
        check("br_over_j_pc_sel", pc_sel, 1);
        cyc();
        zero_ex = 1'b0;

        // Jump with load-use stall: stall first, redirect next cycle
        set_id(OP_LW, 5'd1, 5'd8);
        cyc();
        set_id(OP_J, 5'd8, 5'd0);
        check("jst_pc_write", pc_write, 0);
        check("jst_pc_sel", pc_sel, 0);
        check("jst_ifid_flush", ifid_flush, 0);
        cyc();
        check("jst_cnt", stall_cnt, 3);
        check("jst_pc_sel_next", pc_sel, 2);
        check("jst_flush_next", ifid_flush, 1);

        // Counter saturation at 2^CNT_W-1
        set_id(OP_LW, 5'd1, 5'd8);
        cyc();
        set_id(OP_R, 5'd8, 5'd0);
        check("sat_stall", pc_write, 0);
        cyc();
        check("sat_cnt", stall_cnt, 3);

        // Illegal opcode
        set_id(OP_BAD, 5'd0, 5'd0);
        check("bad_ext_sel", ext_sel_id, 0);
        cyc();
        check("bad_ex_reg_dst", ex_reg_dst, 0);
        check("bad_ex_alu_src", ex_alu_src, 0);
        check("bad_ex_alu_op", ex_alu_op, 0);
        check("bad_illegal_op", illegal_op, 1);
        set_id(OP_R, 5'd0, 5'd0);
        cyc();
        check("bad_pulse_end", illegal_op, 0);

        // Illegal opcode squashed by a taken branch is not reported
        set_id(OP_BEQ, 5'd1, 5'd2);
        cyc();
        zero_ex = 1'b1;
        set_id(OP_BAD, 5'd0, 5'd0);
        cyc();
        zero_ex = 1'b0;
        check("bad_flushed", illegal_op, 0);

        // Asynchronous reset with LW in MEM
        set_id(OP_LW, 5'd1, 5'd2);
        cyc();
        set_id(OP_R, 5'd0, 5'd0);
        cyc();
        check("pre_rst_mem_read", mem_read, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_mem_read", mem_read, 0);
        check("mid_rst_wb_reg_write", wb_reg_write, 0);
        check("mid_rst_pc_write", pc_write, 1);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_ex_reg_dst", ex_reg_dst, 0);
        rst = 1'b1;
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
